// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-order issue scoreboard tracking in-flight destination registers
module hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    input  logic [4:0]       issue_rd,
    input  logic             issue_reg_wen,
    input  logic             wb_wen,
    input  logic [4:0]       wb_waddr,
    input  logic             commit,
    input  logic             flush,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] inflight,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [31:1]      busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [31:0] busy_full;
    logic        raw1, raw2, waw, full, fire;
    logic [31:1] set_vec, clr_vec;
    logic        clr_err, cnt_err;

    // Bit 0 reads as zero so register x0 can never raise a hazard.
    assign busy_full = {busy_q, 1'b0};

    assign raw1 = issue_use_rs1 && busy_full[issue_rs1];
    assign raw2 = issue_use_rs2 && busy_full[issue_rs2];
    assign waw  = issue_reg_wen && busy_full[issue_rd];
    assign full = (count_q >= MAX_CNT);

    assign issue_ready = !flush && !raw1 && !raw2 && !waw && !full;
    assign fire        = issue_valid && issue_ready;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 1; i < 32; i++) begin
            set_vec[i] = fire && issue_reg_wen && (issue_rd == 5'(i));
            clr_vec[i] = wb_wen && (wb_waddr == 5'(i));
        end
    end

    // Releasing a register that is not tracked is a protocol error; a same-index
    // set/clear can only reach here with the bit clear, so it is flagged too.
    assign clr_err = wb_wen && (wb_waddr != 5'd0) && !busy_full[wb_waddr];
    assign cnt_err = commit && (count_q == '0);

    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end else begin
            busy_d = (busy_q | set_vec) & ~clr_vec;
            if (fire && !commit) begin
                count_d = count_q + 1'b1;
            end else if (commit && !fire && (count_q != '0)) begin
                count_d = count_q - 1'b1;
            end
            if (clr_err || cnt_err) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign busy_vec = busy_full;
    assign inflight = count_q;
    assign err      = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard against a reference model
module tb_hazard_scoreboard;

    localparam int MAXF = 4;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_ready;
    logic [4:0]    issue_rs1, issue_rs2, issue_rd, wb_waddr;
    logic          issue_use_rs1, issue_use_rs2, issue_reg_wen;
    logic          wb_wen, commit, flush;
    logic [31:0]   busy_vec;
    logic [CW-1:0] inflight;
    logic          err;

    hazard_scoreboard #(.MAX_INFLIGHT(MAXF), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd), .issue_reg_wen(issue_reg_wen),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .commit(commit), .flush(flush),
        .busy_vec(busy_vec), .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        chk_ready;
        bit        ready;
        bit [31:0] busy;
        int        cnt;
        bit        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain arrays and integers.
    bit m_busy[32];
    int m_cnt;
    bit m_err;

    task automatic step(input bit r, input bit v, input int rs1, input bit u1,
                        input int rs2, input bit u2, input int rd, input bit wen,
                        input bit wbw, input int wa, input bit cm, input bit fl);
        exp_t e;
        bit   rdy, fire, old_busy[32];
        @(negedge clk);
        rst = r; issue_valid = v;
        issue_rs1 = 5'(rs1); issue_use_rs1 = u1;
        issue_rs2 = 5'(rs2); issue_use_rs2 = u2;
        issue_rd = 5'(rd); issue_reg_wen = wen;
        wb_wen = wbw; wb_waddr = 5'(wa); commit = cm; flush = fl;

        rdy = !fl && !(u1 && rs1 != 0 && m_busy[rs1]) && !(u2 && rs2 != 0 && m_busy[rs2])
              && !(wen && rd != 0 && m_busy[rd]) && (m_cnt < MAXF);
        fire = v && rdy;
        e.chk_ready = !r;
        e.ready = rdy;
        old_busy = m_busy;
        if (r) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_cnt = 0; m_err = 0;
        end else if (fl) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_cnt = 0;
        end else begin
            if (fire && wen && rd != 0) m_busy[rd] = 1;
            if (wbw && wa != 0) begin
                if (!old_busy[wa]) m_err = 1;
                m_busy[wa] = 0;
            end
            if (cm && m_cnt == 0) m_err = 1;
            if (fire && !cm) m_cnt++;
            else if (cm && !fire && m_cnt > 0) m_cnt--;
        end
        e.busy = '0;
        for (int i = 1; i < 32; i++) e.busy[i] = m_busy[i];
        e.cnt = m_cnt;
        e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: ready is checked mid-cycle, registered state just after the edge.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (sb.size() > 0 && sb[0].chk_ready) chk("issue_ready", 32'(issue_ready), 32'(sb[0].ready));
            @(posedge clk); #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("busy_vec", busy_vec, e.busy);
                chk("inflight", 32'(inflight), 32'(e.cnt));
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        int rs1, rs2, rd, wa;
        bit v, u1, u2, wen, wbw, cm, fl, r;
        rst = 1; issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_use_rs1 = 0;
        issue_use_rs2 = 0; issue_rd = 0; issue_reg_wen = 0; wb_wen = 0; wb_waddr = 0;
        commit = 0; flush = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        m_cnt = 0; m_err = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // RAW stall and release one cycle after the write strobe
        step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0, 6, 1, 1, 5, 1, 0);
        step(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0);
        // x0 never tracked; unused rs2 never stalls
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 8, 0, 0, 0, 1, 8, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // occupancy limit and fire+commit at count 3
        for (int i = 1; i <= 4; i++) step(0, 1, 0, 0, 0, 0, i, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0);
        step(0, 1, 0, 0, 0, 0, 11, 1, 1, 11, 1, 0);
        // flush overrides wb_wen and commit
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 13, 1, 1, 9, 1, 1);
        // commit underflow, sticky through flush, cleared by reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // release of idle reg flags err while a concurrent fire still sets busy
        step(0, 1, 0, 0, 0, 0, 3, 1, 1, 12, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            v   = ($urandom_range(0, 3) != 0);
            rs1 = $urandom_range(0, 7); u1 = $urandom_range(0, 1);
            rs2 = $urandom_range(0, 7); u2 = $urandom_range(0, 1);
            rd  = $urandom_range(0, 7); wen = ($urandom_range(0, 3) != 0);
            wbw = ($urandom_range(0, 2) == 0);
            wa  = $urandom_range(0, 7);
            for (int k = 0; k < 4; k++) if (wbw && !m_busy[wa]) wa = $urandom_range(0, 7);
            cm  = ($urandom_range(0, 2) == 0) && (m_cnt > 0 || $urandom_range(0, 19) == 0);
            step(r, v, rs1, u1, rs2, u2, rd, wen, wbw, wa, cm, fl);
        end
        idle(2);

        for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
